// File: rtl/ps2_host_tx.sv
// ----------------------------------------------------------------------------
// ps2_host_tx
//   PS/2 host-to-device transmitter. Sends one command byte to the device over
//   the shared open-drain PS2_CLK / PS2_DAT bus. The host inhibits the bus and
//   issues a request-to-send. After that the device clocks the frame in
//   (start, D0..D7, odd parity, stop), then returns an ACK bit.
//
//   Optional watchdog: define PS2_TX_TIMEOUT_EN to abort a transfer whose
//   device stops clocking. When the watchdog fires the transfer ends with
//   tx_err=1.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   tx_data      byte to send, captured when the request is accepted
//   tx_start     transfer request, accepted only in IDLE
//   tx_busy      high from accept until the DONE cycle
//   tx_done      one-cycle end-of-transfer pulse
//   tx_err       one-cycle pulse with tx_done when the transfer failed
//   ps2_clk_in   raw PS/2 clock line (asynchronous)
//   ps2_dat_in   raw PS/2 data line (asynchronous)
//   ps2_clk_oe   1 = pull PS/2 clock low
//   ps2_dat_oe   1 = pull PS/2 data low
//
// State      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | bus released, waiting for tx_start
// INHIBIT    | clock held low, data released
// START      | clock and data held low (start bit / request-to-send)
// SHIFT      | clock released; drive next bit on each device clock fall
// ACK        | stop bit out; sample device ACK on the next fall
// WAIT_IDLE  | wait for both lines to return high
// DONE       | tx_done (and tx_err on failure) for one cycle
// ----------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int SETUP_CYCLES   = 200,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE,
    S_DONE
  } state_t;

  state_t           state;
  logic             clk_meta, clk_sync, clk_prev;
  logic             dat_meta, dat_sync;
  logic             fall;
  logic [8:0]       shreg;      // {parity, data}; bit 0 is the next bit out
  logic [3:0]       bit_idx;
  logic [CNT_W-1:0] cnt;
  logic             ack_ok;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
`else
  // Without the watchdog TIMEOUT_CYCLES has no effect.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  // Synchronizers reset to the idle-high bus level so reset never looks like a fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      clk_prev <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= ps2_clk_in;
      clk_sync <= clk_meta;
      clk_prev <= clk_sync;
      dat_meta <= ps2_dat_in;
      dat_sync <= dat_meta;
    end
  end

  assign fall = clk_prev & ~clk_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      shreg      <= '0;
      bit_idx    <= '0;
      cnt        <= '0;
      ack_ok     <= 1'b0;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_err     <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wd_cnt     <= '0;
`endif
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (tx_start) begin
            shreg      <= {~^tx_data, tx_data};
            tx_busy    <= 1'b1;
            ps2_clk_oe <= 1'b1;
            ps2_dat_oe <= 1'b0;
            cnt        <= CNT_W'(INHIBIT_CYCLES - 1);
            state      <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          if (cnt == '0) begin
            ps2_dat_oe <= 1'b1;
            cnt        <= CNT_W'(SETUP_CYCLES - 1);
            state      <= S_START;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_START: begin
          if (cnt == '0) begin
            ps2_clk_oe <= 1'b0;
            bit_idx    <= '0;
            state      <= S_SHIFT;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        // Falls 1..9 put D0..D7 then parity on the line; fall 10 releases it (stop).
        S_SHIFT: begin
          if (fall) begin
            if (bit_idx == 4'd9) begin
              ps2_dat_oe <= 1'b0;
              state      <= S_ACK;
            end else begin
              ps2_dat_oe <= ~shreg[0];
              shreg      <= {1'b0, shreg[8:1]};
              bit_idx    <= bit_idx + 4'd1;
            end
          end
        end

        S_ACK: begin
          if (fall) begin
            ack_ok <= ~dat_sync;
            state  <= S_WAIT_IDLE;
          end
        end

        S_WAIT_IDLE: begin
          if (clk_sync && dat_sync) begin
            tx_done <= 1'b1;
            tx_err  <= ~ack_ok;
            tx_busy <= 1'b0;
            state   <= S_DONE;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase

`ifdef PS2_TX_TIMEOUT_EN
      // Overrides the normal transitions above when the device stalls.
      if (state == S_START && cnt == '0) begin
        wd_cnt <= '0;
      end else if (state == S_SHIFT || state == S_ACK || state == S_WAIT_IDLE) begin
        if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          tx_done    <= 1'b1;
          tx_err     <= 1'b1;
          tx_busy    <= 1'b0;
          state      <= S_DONE;
        end else begin
          wd_cnt <= wd_cnt + WD_W'(1);
        end
      end
`endif
    end
  end

endmodule
